// File: rtl/ps2_key_frontend.sv
// ps2_key_frontend: PS/2 keyboard line deserialiser producing the ps2_key event word
// Ports:
//   clk_sys   - system clock, sole clock domain
//   reset     - synchronous active-high reset
//   ps2_clk   - raw PS/2 clock (async, idle high)
//   ps2_data  - raw PS/2 data (async)
//   ps2_key   - {toggle, pressed, extended, code[7:0]}; toggle flips on each key event
//   frame_err - one-cycle pulse when a frame is discarded
//   busy      - high while a frame is being received
module ps2_key_frontend #(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] tcnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic          ext;
    logic          brk;
    logic          dat;
    logic          fall;
    logic          timeout;
    assign dat = dat_sync[1];
    // filt_cnt holds how many differing samples precede the current one, so the
    // FILTER_CYCLES-th differing sample is the one that flips the level
    assign fall = filt_level && !clk_sync[1] && filt_cnt == FW'(FILTER_CYCLES - 1);
    // a fall on the same cycle wins over an expiring timeout
    assign timeout = state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            tcnt       <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            if (clk_sync[1] == filt_level)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                filt_level <= clk_sync[1];
                filt_cnt   <= '0;
            end else
                filt_cnt <= filt_cnt + 1'b1;
            if (fall)
                tcnt <= '0;
            else if (state != IDLE && tcnt != TW'(TIMEOUT_CYCLES))
                tcnt <= tcnt + 1'b1;
        end
    end
    always_ff @(posedge clk_sys) begin
        frame_err <= 1'b0;
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            ps2_key <= '0;
        end else if (timeout) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat) begin
                        state   <= DATA;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end
                end
                DATA: begin
                    shreg   <= {dat, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= PARITY;
                end
                PARITY: begin
                    parity <= dat;
                    state  <= STOP;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (dat && (^shreg ^ parity)) begin
                        if (shreg == 8'hE0)
                            ext <= 1'b1;
                        else if (shreg == 8'hF0)
                            brk <= 1'b1;
                        else begin
                            ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
                            ext     <= 1'b0;
                            brk     <= 1'b0;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_key_frontend.sv
// tb_ps2_key_frontend: frame-level model plus directed PS/2 frames for ps2_key_frontend
module tb_ps2_key_frontend;
    localparam int T    = 200;
    localparam int F    = 4;
    localparam int HALF = 40;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;
    ps2_key_frontend #(.TIMEOUT_CYCLES(T), .FILTER_CYCLES(F)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_key(ps2_key), .frame_err(frame_err), .busy(busy)
    );
    always #5 clk_sys = ~clk_sys;
    typedef struct {int e; logic b;} ev_t;
    ev_t         q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          err_cyc = 0;
    int          stim_last = 0;
    int          nb = 0;
    int          last_edge = 0;
    logic [10:0] frame = '0;
    logic [10:0] m_key = '0;
    logic        m_err = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    // Frame-level model: collect the 11 bits of a frame, then judge it as a whole
    task automatic model_bit(input logic b);
        logic [7:0] byte_v;
        last_edge = cyc;
        if (nb == 0) begin
            if (b) begin
                m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
            end else begin
                nb = 1; m_busy = 1'b1;
            end
        end else begin
            frame[nb] = b;
            nb++;
            if (nb == 11) begin
                byte_v = frame[8:1];
                if (frame[10] && (^byte_v ^ frame[9])) begin
                    if (byte_v == 8'hE0) m_ext = 1'b1;
                    else if (byte_v == 8'hF0) m_brk = 1'b1;
                    else begin
                        m_key = {~m_key[10], ~m_brk, m_ext, byte_v};
                        m_ext = 1'b0; m_brk = 1'b0;
                    end
                end else begin
                    m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
                end
                nb = 0; m_busy = 1'b0;
            end
        end
    endtask
    always @(posedge clk_sys) begin
        ev_t ev;
        cyc++;
        m_err = 1'b0;
        if (reset) begin
            q.delete();
            nb = 0; m_key = '0; m_busy = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        end else if (q.size() > 0 && q[0].e == cyc) begin
            ev = q.pop_front();
            model_bit(ev.b);
        end else if (nb > 0 && cyc == last_edge + T) begin
            m_err = 1'b1; nb = 0; m_busy = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        end
    end
    always @(negedge clk_sys) begin
        if (cyc >= 1) begin
            checks += 3;
            if (ps2_key !== m_key) begin
                errors++;
                $display("FAIL key cyc=%0d got %h want %h", cyc, ps2_key, m_key);
            end
            if (frame_err !== m_err) begin
                errors++;
                $display("FAIL frame_err cyc=%0d got %b want %b", cyc, frame_err, m_err);
            end
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, m_busy);
            end
            if (frame_err === 1'b1) begin
                pulses++;
                err_cyc = cyc;
            end
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask
    task automatic fall_bit(input logic b);
        ev_t ev;
        ps2_data = b;
        repeat (HALF / 2) @(negedge clk_sys);
        ps2_clk = 1'b0;
        ev.e = cyc + F + 2;
        ev.b = b;
        stim_last = ev.e;
        q.push_back(ev);
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk_sys);
    endtask
    task automatic send(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, ~(^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) fall_bit(fr[i]);
    endtask
    task automatic glitch();
        ps2_clk = 1'b0;
        repeat (F - 1) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk_sys);
    endtask
    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        logic [7:0]  fr8;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        check("reset key", 32'(ps2_key), 32'h000);
        check("reset err", 32'(frame_err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        send(8'h29, 1'b0, 11);
        check("make 29", 32'(ps2_key), 32'h629);
        check("no err", 32'(pulses), 32'd0);
        send(8'hF0, 1'b0, 11);
        check("F0 alone", 32'(ps2_key), 32'h629);
        send(8'h29, 1'b0, 11);
        check("break 29", 32'(ps2_key), 32'h029);
        do_reset();
        send(8'hE0, 1'b0, 11);
        send(8'h75, 1'b0, 11);
        check("ext make 75", 32'(ps2_key), 32'h775);
        send(8'hE0, 1'b0, 11);
        send(8'hF0, 1'b0, 11);
        send(8'h75, 1'b0, 11);
        check("ext break 75", 32'(ps2_key), 32'h175);
        send(8'hE0, 1'b0, 11);
        send(8'h75, 1'b1, 11);
        check("parity err key", 32'(ps2_key), 32'h175);
        check("parity err pulse", 32'(pulses), 32'd1);
        send(8'h75, 1'b0, 11);
        check("ext cleared", 32'(ps2_key), 32'h675);
        send(8'hE0, 1'b0, 11);
        fall_bit(1'b1);
        check("bad start pulse", 32'(pulses), 32'd2);
        send(8'h75, 1'b0, 11);
        check("bad start clears ext", 32'(ps2_key), 32'h275);
        send(8'h1C, 1'b0, 5);
        check("busy mid frame", 32'(busy), 32'h1);
        repeat (T + 20) @(negedge clk_sys);
        check("timeout pulse", 32'(pulses), 32'd3);
        check("timeout delay", 32'(err_cyc - stim_last), 32'(T));
        check("timeout busy", 32'(busy), 32'h0);
        send(8'h1C, 1'b0, 11);
        check("after timeout", 32'(ps2_key), 32'h61C);
        glitch();
        repeat (20) @(negedge clk_sys);
        check("idle glitch busy", 32'(busy), 32'h0);
        check("idle glitch err", 32'(pulses), 32'd3);
        fr8 = 8'h5A;
        fall_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            fall_bit(fr8[i]);
            if (i == 3) glitch();
        end
        fall_bit(~(^fr8));
        glitch();
        fall_bit(1'b1);
        check("glitch frame", 32'(ps2_key), 32'h25A);
        check("glitch no err", 32'(pulses), 32'd3);
        send(8'h33, 1'b0, 5);
        do_reset();
        check("mid reset key", 32'(ps2_key), 32'h000);
        check("mid reset busy", 32'(busy), 32'h0);
        repeat (T + 20) @(negedge clk_sys);
        check("mid reset no err", 32'(pulses), 32'd3);
        send(8'h29, 1'b0, 11);
        check("after reset", 32'(ps2_key), 32'h629);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
